mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a CPU port and a loader port onto one memory with one-cycle read latency.
// Optional feature: define MEM_ARB_LOCK_EN to add the ldr_lock input (loader keeps the memory).
module mem_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic              ldr_lock,
`endif
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_LDR, RESP} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [3:0] streak, streak_nxt;
    logic [1:0] owner_nxt;
    logic       acc_rd;
    logic       pick_cpu, pick_ldr;
    logic       hold_ldr;

`ifdef MEM_ARB_LOCK_EN
    logic last_ldr;
    assign hold_ldr = ldr_lock && last_ldr;
`else
    assign hold_ldr = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nxt  = state;
        streak_nxt = streak;
        owner_nxt  = owner;
        pick_cpu   = 1'b0;
        pick_ldr   = 1'b0;
        case (state)
            GNT_CPU, GNT_LDR: state_nxt = RESP;
            default: begin
                // IDLE and RESP both arbitrate, so back-to-back accesses take two cycles each.
                if (hold_ldr) begin
                    pick_ldr = ldr_req;
                end else begin
                    pick_ldr = ldr_req && (!cpu_req || streak == LIMIT);
                    pick_cpu = cpu_req && !pick_ldr;
                end
                if (pick_ldr) begin
                    state_nxt = GNT_LDR;
                    owner_nxt = 2'b10;
                end else if (pick_cpu) begin
                    state_nxt = GNT_CPU;
                    owner_nxt = 2'b01;
                end else begin
                    state_nxt = IDLE;
                    owner_nxt = 2'b00;
                end
            end
        endcase
        if (!ldr_req || pick_ldr)
            streak_nxt = '0;
        else if (pick_cpu && streak != LIMIT)
            streak_nxt = streak + 4'd1;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state  <= IDLE;
            streak <= '0;
            owner  <= 2'b00;
            acc_rd <= 1'b0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
            owner  <= owner_nxt;
            if (state == GNT_CPU)
                acc_rd <= !cpu_we;
            else if (state == GNT_LDR)
                acc_rd <= !ldr_we;
        end
    end

`ifdef MEM_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset)
            last_ldr <= 1'b0;
        else if (pick_ldr)
            last_ldr <= 1'b1;
        else if (pick_cpu)
            last_ldr <= 1'b0;
    end
`endif

    assign cpu_gnt    = (state == GNT_CPU);
    assign ldr_gnt    = (state == GNT_LDR);
    assign mem_en     = cpu_gnt || ldr_gnt;
    assign mem_we     = (cpu_gnt && cpu_we) || (ldr_gnt && ldr_we);
    assign mem_addr   = ldr_gnt ? ldr_addr  : cpu_addr;
    assign mem_wdata  = ldr_gnt ? ldr_wdata : cpu_wdata;

    // owner still names the granted port during RESP, which routes the read response.
    assign cpu_rvalid = (state == RESP) && (owner == 2'b01) && acc_rd;
    assign ldr_rvalid = (state == RESP) && (owner == 2'b10) && acc_rd;
    assign cpu_rdata  = mem_rdata;
    assign ldr_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a behavioural memory.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       ldr_req, ldr_we, ldr_gnt, ldr_rvalid;
    logic [7:0] ldr_addr, ldr_wdata, ldr_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0] owner;
`ifdef MEM_ARB_LOCK_EN
    logic       ldr_lock;
`endif

    logic       bd_we;
    logic [7:0] bd_addr, bd_data;
    logic [7:0] mem    [256];
    logic [7:0] shadow [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
`ifdef MEM_ARB_LOCK_EN
        .ldr_lock(ldr_lock),
`endif
        .owner(owner)
    );

    // Synchronous memory with one-cycle read latency and a backdoor preload port.
    always @(posedge clk) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
        else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    function automatic logic [7:0] ctrl_vec();
        return {cpu_gnt, ldr_gnt, mem_en, mem_we, cpu_rvalid, ldr_rvalid, owner};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
        bd_we = 0; bd_addr = 0; bd_data = 0;
`ifdef MEM_ARB_LOCK_EN
        ldr_lock = 0;
`endif
    endtask

    task automatic test_reset();
        logic [7:0] c;
        reset = 1; cpu_req = 1; ldr_req = 1; ldr_we = 1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            @(negedge clk);
            c = ctrl_vec();
            checks++;
            if (c !== 8'h00) begin
                failures++;
                $display("FAIL reset_ctrl[%0d]: got %b want 00000000", i, c);
            end
        end
        clear_inputs();
        reset = 0;
        cyc();
    endtask

    task automatic test_cpu_read();
        logic [7:0] c;
        reset = 1; bd_we = 1; bd_addr = 8'h10; bd_data = 8'hA5;
        cyc();
        bd_we = 0; reset = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        @(negedge clk); c = ctrl_vec(); checks++;
        if (c !== 8'h00) begin failures++; $display("FAIL cpu_read_c0: got %b want 00000000", c); end
        cyc();
        @(negedge clk); c = ctrl_vec(); checks++;
        if (c !== 8'b1010_0001 || mem_addr !== 8'h10) begin
            failures++; $display("FAIL cpu_read_c1: got ctrl %b addr %h want 10100001 addr 10", c, mem_addr);
        end
        cyc();
        cpu_req = 0;
        @(negedge clk); c = ctrl_vec(); checks++;
        if (c !== 8'b0000_1001) begin failures++; $display("FAIL cpu_read_c2: got %b want 00001001", c); end
        checks++;
        if (cpu_rdata !== 8'hA5) begin failures++; $display("FAIL cpu_read_data: got %h want a5", cpu_rdata); end
        cyc();
        @(negedge clk); c = ctrl_vec(); checks++;
        if (c !== 8'h00) begin failures++; $display("FAIL cpu_read_c3: got %b want 00000000", c); end
    endtask

    task automatic test_ldr_write_cpu_read();
        logic [7:0] c;
        cyc();
        ldr_req = 1; ldr_we = 1; ldr_addr = 8'h20; ldr_wdata = 8'h3C;
        @(negedge clk); c = ctrl_vec(); checks++;
        if (c !== 8'h00) begin failures++; $display("FAIL ldr_wr_idle: got %b want 00000000", c); end
        cyc();
        @(negedge clk); c = ctrl_vec(); checks++;
        if (c !== 8'b0111_0010 || mem_addr !== 8'h20 || mem_wdata !== 8'h3C) begin
            failures++;
            $display("FAIL ldr_wr_gnt: got ctrl %b addr %h wdata %h want 01110010 20 3c", c, mem_addr, mem_wdata);
        end
        cyc();
        ldr_req = 0; ldr_we = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
        @(negedge clk); c = ctrl_vec(); checks++;
        if (c !== 8'b0000_0010) begin failures++; $display("FAIL ldr_wr_resp: got %b want 00000010", c); end
        cyc();
        @(negedge clk); c = ctrl_vec(); checks++;
        if (c !== 8'b1010_0001) begin failures++; $display("FAIL ldr_cpu_gnt: got %b want 10100001", c); end
        cyc();
        cpu_req = 0;
        @(negedge clk); c = ctrl_vec(); checks++;
        if (c !== 8'b0000_1001) begin failures++; $display("FAIL ldr_cpu_resp: got %b want 00001001", c); end
        checks++;
        if (cpu_rdata !== 8'h3C) begin failures++; $display("FAIL ldr_cpu_data: got %h want 3c", cpu_rdata); end
        cyc();
    endtask

    task automatic test_starvation();
        logic [1:0] got, want;
        cyc();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01;
        ldr_req = 1; ldr_we = 0; ldr_addr = 8'h02;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) cyc();
            @(negedge clk);
            // Grants land on odd cycles; every fifth grant goes to the loader.
            want = 2'b00;
            if (i % 2 == 1) want = (((i - 1) / 2) % (LIMIT + 1) == LIMIT) ? 2'b01 : 2'b10;
            got = {cpu_gnt, ldr_gnt};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL starve_cycle%0d: got {cpu,ldr}=%b want %b", i, got, want);
            end
        end
        cyc();
        cpu_req = 0; ldr_req = 0;
        cyc();
    endtask

    task automatic test_reset_abort();
        logic [7:0] c;
        cyc();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        cyc();
        @(negedge clk); c = ctrl_vec(); checks++;
        if (c !== 8'b1010_0001) begin failures++; $display("FAIL abort_gnt: got %b want 10100001", c); end
        reset = 1;
        cyc();
        cpu_req = 0;
        @(negedge clk); c = ctrl_vec(); checks++;
        if (c !== 8'h00) begin failures++; $display("FAIL abort_after: got %b want 00000000", c); end
        reset = 0;
        cyc();
        @(negedge clk); c = ctrl_vec(); checks++;
        if (c !== 8'h00) begin failures++; $display("FAIL abort_late: got %b want 00000000", c); end
    endtask

    task automatic test_random();
        int         m_gnt, m_rv, m_streak, w, last_gnt;
        logic [1:0] m_owner;
        logic       g_we;
        logic [7:0] g_addr, g_wdata, m_rdata, exp_c, c, rd;
        clear_inputs();
        reset = 1;
        repeat (2) cyc();
        reset = 0;
        shadow = mem;
        m_gnt = 0; m_rv = 0; m_streak = 0; last_gnt = 0; m_owner = 2'b00;
        g_we = 0; g_addr = 0; g_wdata = 0; m_rdata = 0;
        for (int n = 0; n < 600; n++) begin
            cyc();
            // A granted requester re-issues; a waiting one holds or occasionally withdraws.
            if (last_gnt == 1 || !cpu_req) begin
                cpu_req = ($urandom % 4) != 0; cpu_we = 1'($urandom);
                cpu_addr = 8'($urandom % 16); cpu_wdata = 8'($urandom);
            end else if ($urandom % 10 == 0) cpu_req = 0;
            if (last_gnt == 2 || !ldr_req) begin
                ldr_req = ($urandom % 4) != 0; ldr_we = 1'($urandom);
                ldr_addr = 8'($urandom % 16); ldr_wdata = 8'($urandom);
            end else if ($urandom % 10 == 0) ldr_req = 0;
            @(negedge clk);
            exp_c = {m_gnt == 1, m_gnt == 2, m_gnt != 0, m_gnt != 0 && g_we, m_rv == 1, m_rv == 2, m_owner};
            c = ctrl_vec();
            checks++;
            if (c !== exp_c) begin
                failures++; $display("FAIL rand_ctrl@%0d: got %b want %b", n, c, exp_c);
            end
            if (m_gnt != 0) begin
                checks++;
                if (mem_addr !== g_addr || (g_we && mem_wdata !== g_wdata)) begin
                    failures++;
                    $display("FAIL rand_mem@%0d: got addr %h wdata %h want %h %h", n, mem_addr, mem_wdata, g_addr, g_wdata);
                end
            end
            if (m_rv != 0) begin
                rd = (m_rv == 1) ? cpu_rdata : ldr_rdata;
                checks++;
                if (rd !== m_rdata) begin
                    failures++; $display("FAIL rand_rdata@%0d: got %h want %h", n, rd, m_rdata);
                end
            end
            last_gnt = m_gnt;
            if (m_gnt != 0) begin
                if (g_we) begin shadow[g_addr] = g_wdata; m_rv = 0; end
                else begin m_rdata = shadow[g_addr]; m_rv = m_gnt; end
                m_gnt = 0;
                if (!ldr_req) m_streak = 0;
            end else begin
                m_rv = 0;
                if (cpu_req && ldr_req) w = (m_streak == LIMIT) ? 2 : 1;
                else if (cpu_req)       w = 1;
                else if (ldr_req)       w = 2;
                else                    w = 0;
                if (!ldr_req || w == 2)            m_streak = 0;
                else if (w == 1 && m_streak < LIMIT) m_streak++;
                m_gnt = w;
                m_owner = 2'(w);
                if (w == 1) begin g_we = cpu_we; g_addr = cpu_addr; g_wdata = cpu_wdata; end
                if (w == 2) begin g_we = ldr_we; g_addr = ldr_addr; g_wdata = ldr_wdata; end
            end
        end
        clear_inputs();
        repeat (3) cyc();
    endtask

`ifdef MEM_ARB_LOCK_EN
    task automatic test_lock();
        int lg, cg;
        clear_inputs();
        reset = 1;
        cyc();
        reset = 0; ldr_lock = 1; ldr_req = 1; ldr_addr = 8'h05;
        cyc();
        @(negedge clk); checks++;
        if (ldr_gnt !== 1'b1) begin failures++; $display("FAIL lock_first: got ldr_gnt %b want 1", ldr_gnt); end
        lg = 0; cg = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            cpu_req = 1; cpu_addr = 8'h06;
            @(negedge clk);
            lg += int'(ldr_gnt);
            cg += int'(cpu_gnt);
        end
        checks++;
        if (lg != 6 || cg != 0) begin
            failures++; $display("FAIL lock_count: got ldr %0d cpu %0d want 6 0", lg, cg);
        end
        cyc();
        ldr_lock = 0;
        cyc();
        @(negedge clk); checks++;
        if (cpu_gnt !== 1'b1) begin failures++; $display("FAIL lock_release: got cpu_gnt %b want 1", cpu_gnt); end
        clear_inputs();
        repeat (2) cyc();
    endtask
`endif

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_cpu_read();
        test_ldr_write_cpu_read();
        test_starvation();
        test_reset_abort();
        test_random();
`ifdef MEM_ARB_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
